// File: rtl/alarm_pkg.sv
// Shared FSM state codes, key actions and the one-hot key decoder used by alarm_zone_ctrl.
package alarm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t DISARMED    = 3'd0;
    localparam state_t EXIT_DELAY  = 3'd1;
    localparam state_t ARMED       = 3'd2;
    localparam state_t ENTRY_DELAY = 3'd3;
    localparam state_t ALARM       = 3'd4;

    localparam int DEF_ARM_KEY    = 4;
    localparam int DEF_DISARM_KEY = 2;
    localparam int KEY_IDX_W      = 5;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_ARM,
        KEY_DISARM,
        KEY_BAD
    } key_act_t;

    typedef struct packed {
        logic                 valid;
        logic [KEY_IDX_W-1:0] idx;
    } key_dec_t;

    // idx is only meaningful when valid is set (exactly one bit high).
    function automatic key_dec_t onehot_idx(input logic [31:0] code);
        key_dec_t d;
        d.valid = (code != '0) && ((code & (code - 32'd1)) == '0);
        d.idx   = '0;
        for (int i = 0; i < 32; i++) begin
            if (code[i]) d.idx = KEY_IDX_W'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter that saturates at zero; expired is high whenever the count is zero.
module alarm_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: keypad arm/disarm, exit/entry delays, sticky alarm with siren timeout.
// Optional macro ALARM_TAMPER_EN adds a tamper input that forces ALARM from any state.
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int                 N_ZONES      = 4,
    parameter logic [N_ZONES-1:0] INSTANT_MASK = 4'b0001,
    parameter int                 KEY_W        = 5,
    parameter int                 ARM_KEY      = DEF_ARM_KEY,
    parameter int                 DISARM_KEY   = DEF_DISARM_KEY,
    parameter int                 EXIT_CYCLES  = 1000,
    parameter int                 ENTRY_CYCLES = 500,
    parameter int                 SIREN_CYCLES = 10000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic [N_ZONES-1:0] zone,
`ifdef ALARM_TAMPER_EN
    input  logic               tamper,
`endif
    output logic               active,
    output logic               alarm,
    output logic [N_ZONES-1:0] zone_trip,
    output logic               key_err,
    output logic [2:0]         state_o
);

    localparam int MAX_DELAY = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int TW        = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
    localparam int SW        = (SIREN_CYCLES > 0) ? $clog2(SIREN_CYCLES + 1) : 1;

    // Delay timer is loaded with N-1 so the transition lands exactly N cycles after the load.
    localparam logic [TW-1:0] EXIT_LOAD  = (EXIT_CYCLES > 0) ? TW'(EXIT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] ENTRY_LOAD = (ENTRY_CYCLES > 0) ? TW'(ENTRY_CYCLES - 1) : '0;
    localparam logic [SW-1:0] SIREN_LOAD = SW'(SIREN_CYCLES);

    localparam logic [N_ZONES-1:0] DELAYED_MASK = ~INSTANT_MASK;

    state_t             state;
    state_t             state_nxt;
    logic [N_ZONES-1:0] trip_nxt;
    logic               dly_load;
    logic [TW-1:0]      dly_value;
    logic               dly_expired;
    logic               siren_load;
    logic               siren_expired;
    logic               timers_clear;
    logic               tamper_hit;
    logic               instant_hit;
    logic               delayed_hit;
    logic [31:0]        key_wide;
    key_dec_t           key_dec;
    key_act_t           key_act;

`ifdef ALARM_TAMPER_EN
    assign tamper_hit = tamper;
`else
    assign tamper_hit = 1'b0;
`endif

    assign key_wide    = 32'(key_code);
    assign key_dec     = onehot_idx(key_wide);
    assign instant_hit = |(zone & INSTANT_MASK);
    assign delayed_hit = |(zone & DELAYED_MASK);

    always_comb begin
        key_act = KEY_NONE;
        if (key_valid) begin
            if (key_dec.valid && key_dec.idx == KEY_IDX_W'(ARM_KEY)) begin
                key_act = KEY_ARM;
            end else if (key_dec.valid && key_dec.idx == KEY_IDX_W'(DISARM_KEY)) begin
                key_act = KEY_DISARM;
            end else begin
                key_act = KEY_BAD;
            end
        end
    end

    // Disarm is checked first in every armed state, so a same-cycle trip is never recorded.
    always_comb begin
        state_nxt  = state;
        trip_nxt   = zone_trip;
        dly_load   = 1'b0;
        dly_value  = '0;
        siren_load = 1'b0;
        case (state)
            DISARMED: begin
                if (key_act == KEY_ARM) begin
                    trip_nxt = '0;
                    if (EXIT_CYCLES == 0) begin
                        state_nxt = ARMED;
                    end else begin
                        state_nxt = EXIT_DELAY;
                        dly_load  = 1'b1;
                        dly_value = EXIT_LOAD;
                    end
                end
            end
            EXIT_DELAY: begin
                if (key_act == KEY_DISARM) begin
                    state_nxt = DISARMED;
                end else if (dly_expired) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (key_act == KEY_DISARM) begin
                    state_nxt = DISARMED;
                end else begin
                    trip_nxt = zone_trip | zone;
                    if (instant_hit || (delayed_hit && ENTRY_CYCLES == 0)) begin
                        state_nxt  = ALARM;
                        siren_load = 1'b1;
                    end else if (delayed_hit) begin
                        state_nxt = ENTRY_DELAY;
                        dly_load  = 1'b1;
                        dly_value = ENTRY_LOAD;
                    end
                end
            end
            ENTRY_DELAY: begin
                if (key_act == KEY_DISARM) begin
                    state_nxt = DISARMED;
                end else begin
                    trip_nxt = zone_trip | zone;
                    if (instant_hit || dly_expired) begin
                        state_nxt  = ALARM;
                        siren_load = 1'b1;
                    end
                end
            end
            ALARM: begin
                if (key_act == KEY_DISARM) begin
                    state_nxt = DISARMED;
                end else begin
                    trip_nxt = zone_trip | zone;
                end
            end
            default: begin
                state_nxt = DISARMED;
            end
        endcase

        if (tamper_hit) begin
            state_nxt  = ALARM;
            siren_load = 1'b1;
            dly_load   = 1'b0;
            trip_nxt   = (state == ARMED || state == ENTRY_DELAY || state == ALARM) ?
                         (zone_trip | zone) : zone_trip;
        end
    end

    assign timers_clear = (state_nxt == DISARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DISARMED;
            zone_trip <= '0;
            key_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            zone_trip <= trip_nxt;
            key_err   <= (key_act == KEY_BAD);
        end
    end

    alarm_timer #(
        .W(TW)
    ) u_delay_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timers_clear),
        .load    (dly_load),
        .dec     (state == EXIT_DELAY || state == ENTRY_DELAY),
        .value   (dly_value),
        .expired (dly_expired)
    );

    alarm_timer #(
        .W(SW)
    ) u_siren_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timers_clear),
        .load    (siren_load),
        .dec     (state == ALARM),
        .value   (SIREN_LOAD),
        .expired (siren_expired)
    );

    assign active  = (state != DISARMED);
    assign alarm   = (state == ALARM) && (SIREN_CYCLES == 0 || !siren_expired);
    assign state_o = state;

endmodule
